// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: rotating-priority search, registered one-hot grant with
// binary index, held until release, owner request drop or hold timeout.
module rr_grant_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             release_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o
);

    localparam int unsigned CNT_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int unsigned HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;

    logic               owner_req;
    logic               limit_hit;
    logic               grant_exit;
    logic [IDX_W-1:0]   owner_nxt;
    logic [IDX_W-1:0]   start;
    logic [N-1:0]       cand;
    logic [2*N-1:0]     dbl;
    logic [N-1:0]       rot;
    logic               found;
    int unsigned        off;
    int unsigned        sum;
    logic [IDX_W-1:0]   win;

    assign owner_req  = |(req_i & gnt_q);
    assign limit_hit  = (MAX_HOLD != 0) && (hold_q == CNT_W'(HOLD_LAST));
    assign grant_exit = (state_q == ST_GRANT) && (release_i || !owner_req || limit_hit);
    assign owner_nxt  = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);

    // Winner search: rotate candidates so the start position lands at bit 0.
    always_comb begin
        start = ptr_q;
        cand  = req_i;
        if (state_q == ST_GRANT) begin
            start = owner_nxt;
            cand  = req_i & ~gnt_q;
        end
        dbl   = {cand, cand} >> start;
        rot   = dbl[N-1:0];
        found = 1'b0;
        off   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        sum = 32'(start) + off;
        if (sum >= N) sum = sum - N;
        win = IDX_W'(sum);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_GRANT;
                    gnt_d   = N'(1) << win;
                    idx_d   = win;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (grant_exit) begin
                    ptr_d     = owner_nxt;
                    timeout_d = limit_hit && !release_i && owner_req;
                    hold_d    = '0;
                    if (found) begin
                        gnt_d = N'(1) << win;
                        idx_d = win;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                    end
                end else if (hold_q != '1) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = valid_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter (N=8, MAX_HOLD=4): directed scenarios followed by
// random traffic, all checked against an owner/pointer reference model.
module tb_rr_grant_arbiter;

    localparam int N     = 8;
    localparam int IDX_W = 3;
    localparam int MAXH  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_i;
    logic             release_i;
    logic [N-1:0]     gnt_o;
    logic [IDX_W-1:0] gnt_idx_o;
    logic             gnt_valid_o;
    logic             timeout_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who owns the resource (-1 = nobody), where the next
    // search starts, how long the owner has held it, and the timeout flag.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    rr_grant_arbiter #(.N(N), .IDX_W(IDX_W), .MAX_HOLD(MAXH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .release_i   (release_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    function automatic int find_winner(input int p, input logic [N-1:0] r, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic rel);
        m_to = 1'b0;
        if (m_owner < 0) begin
            m_owner = find_winner(m_ptr, r, -1);
            m_hold  = 0;
        end else begin
            bit still_wants;
            bit at_limit;
            still_wants = r[m_owner];
            at_limit    = (MAXH != 0) && (m_hold == MAXH - 1);
            if (rel || !still_wants || at_limit) begin
                m_to    = at_limit && !rel && still_wants;
                m_ptr   = (m_owner + 1) % N;
                m_owner = find_winner(m_ptr, r, m_owner);
                m_hold  = 0;
            end else begin
                m_hold++;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] e_gnt;
        e_gnt = (m_owner >= 0) ? N'(1) << m_owner : '0;
        check({tag, ".gnt"},     32'(gnt_o),       32'(e_gnt));
        check({tag, ".idx"},     32'(gnt_idx_o),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check({tag, ".valid"},   32'(gnt_valid_o), 32'(m_owner >= 0));
        check({tag, ".timeout"}, 32'(timeout_o),   32'(m_to));
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic rel, input string tag);
        req_i     = r;
        release_i = rel;
        model_step(r, rel);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_i     = 8'hFF;
        release_i = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_model("reset");
        end
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        logic         rel;

        // Reset with all requesters active.
        do_reset();

        // Single requester, then drop.
        cycle(8'h04, 1'b0, "single");
        check("single.idx2", 32'(gnt_idx_o), 32'd2);
        cycle(8'h00, 1'b0, "drop");
        check("drop.gnt0", 32'(gnt_o), 32'd0);

        // Full rotation with release every grant, no idle bubbles.
        do_reset();
        cycle(8'hFF, 1'b0, "rot.first");
        check("rot.idx0", 32'(gnt_idx_o), 32'd0);
        for (int k = 1; k <= N; k++) begin
            cycle(8'hFF, 1'b1, "rot");
            check("rot.seq", 32'(gnt_idx_o), 32'(k % N));
            check("rot.nobubble", 32'(gnt_valid_o), 32'd1);
        end

        // Handover from idx5 wraps past 7 to idx0.
        cycle(8'h20, 1'b1, "to5");
        check("to5.idx", 32'(gnt_idx_o), 32'd5);
        cycle(8'h03, 1'b1, "wrap");
        check("wrap.idx0", 32'(gnt_idx_o), 32'd0);

        // Hold timeout: idx3 owns with release low, revoked after MAXH cycles.
        cycle(8'h08, 1'b1, "to3");
        check("to3.idx", 32'(gnt_idx_o), 32'd3);
        for (int k = 0; k < MAXH - 1; k++) begin
            cycle(8'h09, 1'b0, "hold");
            check("hold.idx3", 32'(gnt_idx_o), 32'd3);
        end
        cycle(8'h09, 1'b0, "tmo");
        check("tmo.pulse", 32'(timeout_o), 32'd1);
        check("tmo.idx0", 32'(gnt_idx_o), 32'd0);
        cycle(8'h09, 1'b0, "tmo.after");
        check("tmo.onecycle", 32'(timeout_o), 32'd0);

        // Release coinciding with the hold limit is a normal exit.
        cycle(8'h00, 1'b0, "idle");
        cycle(8'h80, 1'b0, "lim.grant");
        for (int k = 0; k < MAXH - 1; k++) cycle(8'h80, 1'b0, "lim.hold");
        cycle(8'h80, 1'b1, "lim.rel");
        check("lim.notimeout", 32'(timeout_o), 32'd0);

        // Asynchronous reset in the middle of a grant.
        cycle(8'h10, 1'b0, "pre.async");
        check("pre.async.valid", 32'(gnt_valid_o), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async.gnt",   32'(gnt_o),       32'd0);
        check("async.idx",   32'(gnt_idx_o),   32'd0);
        check("async.valid", 32'(gnt_valid_o), 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        cycle(8'h80, 1'b0, "post.async");
        check("post.async.idx7", 32'(gnt_idx_o), 32'd7);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            r = N'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & N'($urandom);
            if ($urandom_range(0, 15) == 0) r = '0;
            rel = ($urandom_range(0, 3) == 0);
            cycle(r, rel, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
